generador_rebote: RTL and testbench

GENERADOR_REBOTE -- requirements
Module: generador_rebote

---
 rtl/generador_rebote.sv | 110 +++++++++++
 tb/tb_generador_rebote.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/generador_rebote.sv
// Emulated mechanical pushbutton: on request it walks btn_out to a target level
// through an LFSR-timed burst of bounces, holds it stable, then pulses done.
module generador_rebote #(
   parameter logic [7:0]  SEED          = 8'hA5,
   parameter int unsigned BOUNCE_PAIRS  = 2,
   parameter int unsigned MIN_HOLD      = 1,
   parameter int unsigned HOLD_BITS     = 2,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter logic        INIT_LEVEL    = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic level,
   output logic btn_out,
   output logic busy,
   output logic done
);

   localparam int unsigned TOTAL = 2 * BOUNCE_PAIRS + 1;
   localparam int unsigned TW    = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE, DONE} state_t;

   state_t          state;
   logic [7:0]      lfsr;
   logic [3:0]      hold;
   logic [7:0]      settle;
   logic [TW-1:0]   toggles;
   logic            target;
   logic            feedback;
   logic [3:0]      hold_load;

   // x^8 + x^6 + x^5 + x^4 + 1, shifted left
   always_comb begin
      feedback  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
      hold_load = 4'(MIN_HOLD) + 4'(lfsr[HOLD_BITS-1:0]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         btn_out <= INIT_LEVEL;
         busy    <= 1'b0;
         done    <= 1'b0;
         lfsr    <= SEED;
         hold    <= '0;
         settle  <= '0;
         toggles <= '0;
         target  <= INIT_LEVEL;
      end else begin
         lfsr <= {lfsr[6:0], feedback};
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (level != btn_out) begin
                     target  <= level;
                     btn_out <= level;
                     hold    <= hold_load;
                     toggles <= TW'(1);
                     busy    <= 1'b1;
                     if (TOTAL == 1) begin
                        settle <= 8'(SETTLE_CYCLES);
                        state  <= SETTLE;
                     end else begin
                        state  <= BOUNCE;
                     end
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            BOUNCE: begin
               // hold never reaches zero here: <=1 counts as expiry, so no wrap
               if (hold <= 4'd1) begin
                  toggles <= toggles + 1'b1;
                  if (toggles == TW'(TOTAL - 1)) begin
                     btn_out <= target;
                     hold    <= '0;
                     settle  <= 8'(SETTLE_CYCLES);
                     state   <= SETTLE;
                  end else begin
                     btn_out <= ~btn_out;
                     hold    <= hold_load;
                  end
               end else begin
                  hold <= hold - 1'b1;
               end
            end
            SETTLE: begin
               if (settle <= 8'd1) begin
                  settle <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  settle <= settle - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_generador_rebote.sv
// Scoreboard bench for generador_rebote: expected toggle/done timing is derived
// from the LFSR polynomial and timing rules, then checked by a negedge monitor.
module tb_generador_rebote;

   localparam logic [7:0] SEED   = 8'hA5;
   localparam int         PAIRS  = 2;
   localparam int         MINH   = 1;
   localparam int         HBITS  = 2;
   localparam int         SETTLE = 8;
   localparam int         NTOG   = 2 * PAIRS + 1;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic level = 1'b0;
   logic btn_out, busy, done;

   generador_rebote #(
      .SEED(SEED), .BOUNCE_PAIRS(PAIRS), .MIN_HOLD(MINH),
      .HOLD_BITS(HBITS), .SETTLE_CYCLES(SETTLE), .INIT_LEVEL(1'b0)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .level(level),
      .btn_out(btn_out), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // cyc = number of rising edges since reset released
   int cyc = 0;
   always @(posedge clock or posedge reset)
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      int               t0;
      int               done_e;
      int               ntog;
      bit               change;
      bit               lvl;
      logic [7:0][31:0] tog;
   } txn_t;

   txn_t sb[$];
   int   log_t[$];
   bit   m_btn = 1'b0;

   function automatic void check(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void fail(string name, int act, int exp);
      vectors++;
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endfunction

   // LFSR value seen by rising edge number t (edge 1 sees SEED)
   function automatic logic [7:0] lfsr_seen(int t);
      logic [7:0] v = SEED;
      for (int i = 1; i < t; i++) v = {v[6:0], ^(v & 8'hB8)};
      return v;
   endfunction

   function automatic txn_t make_txn(int t0, bit lvl);
      txn_t x;
      int   t;
      x     = '0;
      x.t0  = t0;
      x.lvl = lvl;
      if (lvl == m_btn) begin
         x.done_e = t0;
      end else begin
         x.change = 1'b1;
         x.tog[0] = t0;
         t = t0;
         for (int k = 1; k < NTOG; k++) begin
            t += MINH + (int'(lfsr_seen(t)) % (1 << HBITS));
            x.tog[k] = t;
         end
         x.ntog   = NTOG;
         x.done_e = t + SETTLE;
         m_btn    = lvl;
      end
      return x;
   endfunction

   // Monitor
   bit   prev_btn;
   int   mon_e;
   bit   exp_busy;
   txn_t f;
   always @(negedge clock) begin
      if (reset) begin
         prev_btn = btn_out;
         log_t.delete();
      end else begin
         mon_e = cyc;
         if (btn_out !== prev_btn) begin
            if (sb.size() > 0 && sb[0].change && mon_e >= sb[0].t0 && mon_e <= sb[0].done_e)
               log_t.push_back(mon_e);
            else
               fail("spurious_toggle", mon_e, -1);
            prev_btn = btn_out;
         end
         exp_busy = sb.size() > 0 && sb[0].change && mon_e >= sb[0].t0 && mon_e < sb[0].done_e;
         check("busy", int'(busy), int'(exp_busy));
         if (done) begin
            if (sb.size() == 0) begin
               fail("unexpected_done", mon_e, -1);
            end else begin
               f = sb.pop_front();
               check("done_cycle", mon_e, f.done_e);
               check("toggle_count", log_t.size(), f.ntog);
               for (int i = 0; i < f.ntog && i < log_t.size(); i++)
                  check("toggle_cycle", log_t[i], int'(f.tog[i]));
               check("final_level", int'(btn_out), int'(f.lvl));
               check("busy_in_done", int'(busy), 0);
            end
            log_t.delete();
         end else if (sb.size() > 0 && mon_e > sb[0].done_e) begin
            fail("missing_done", mon_e, sb[0].done_e);
            void'(sb.pop_front());
            log_t.delete();
         end
      end
   end

   // Reference debouncer: follows btn_out once it differs for 8 straight samples
   logic deb = 1'b0;
   int   deb_cnt = 0;
   int   deb_changes = 0;
   always @(posedge clock) begin
      if (btn_out !== deb) begin
         deb_cnt++;
         if (deb_cnt >= 8) begin
            deb = btn_out;
            deb_cnt = 0;
            deb_changes++;
         end
      end else begin
         deb_cnt = 0;
      end
   end

   task automatic issue(input bit lvl, input bit hold_start, output txn_t x);
      @(negedge clock);
      start = 1'b1;
      level = lvl;
      x = make_txn(cyc + 1, lvl);
      sb.push_back(x);
      if (!hold_start) begin
         @(negedge clock);
         start = 1'b0;
         level = 1'($urandom);
      end
   endtask

   task automatic wait_idle(input bit noise);
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clock);
         n++;
         if (noise && sb.size() > 0 && cyc < sb[0].done_e - 1) begin
            start = 1'($urandom);
            level = 1'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      if (sb.size() != 0) begin
         fail("timeout", n, 0);
         sb.delete();
      end
      start = 1'b0;
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      sb.delete();
      m_btn = 1'b0;
      #1;
      check("async_rst_btn", int'(btn_out), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_done", int'(done), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      txn_t x, y;
      int   rel;
      #1 reset = 1'b1;
      #11;
      check("reset_btn", int'(btn_out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      @(negedge clock);
      reset = 1'b0;

      // 0 -> 1 sequence
      repeat (3) @(negedge clock);
      issue(1'b1, 1'b0, x);
      wait_idle(1'b0);

      // same level: immediate done, no toggles
      issue(1'b1, 1'b0, x);
      wait_idle(1'b0);

      // reset while bouncing
      issue(1'b0, 1'b0, x);
      @(negedge clock);
      async_reset();

      // reset while settling, then replay the first sequence's timing
      repeat (3) @(negedge clock);
      issue(1'b1, 1'b0, x);
      while (cyc < int'(x.tog[NTOG-1]) + 3) @(negedge clock);
      async_reset();
      repeat (3) @(negedge clock);
      issue(1'b1, 1'b0, x);
      wait_idle(1'b0);

      // start held through a full 1 -> 0 -> 1 sequence
      issue(1'b0, 1'b0, x);
      wait_idle(1'b0);
      issue(1'b1, 1'b1, x);
      y = make_txn(x.done_e + 2, 1'b1);
      sb.push_back(y);
      while (cyc < y.t0) @(negedge clock);
      start = 1'b0;
      wait_idle(1'b0);

      // random requests with ignored start/level noise while busy
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 4)) @(negedge clock);
         issue(1'($urandom), 1'b0, x);
         wait_idle(1'b1);
      end

      // 0 -> 1 -> 0 through the debouncer
      issue(1'b0, 1'b0, x);
      wait_idle(1'b0);
      repeat (12) @(negedge clock);
      rel = deb_changes;
      issue(1'b1, 1'b0, x);
      wait_idle(1'b0);
      repeat (12) @(negedge clock);
      issue(1'b0, 1'b0, x);
      wait_idle(1'b0);
      repeat (12) @(negedge clock);
      check("debounced_edges", deb_changes - rel, 2);

      repeat (4) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
